// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake and operand/result bundle for serial_adder_ctrl.
// The overflow signal exists only when SERIAL_ADDER_OVERFLOW_EN is defined.
interface serial_adder_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic             overflow;
`endif

   modport master (
      output start, a, b, c_in,
`ifdef SERIAL_ADDER_OVERFLOW_EN
      input  overflow,
`endif
      input  busy, done, sum, c_out
   );

   modport slave (
      input  start, a, b, c_in,
`ifdef SERIAL_ADDER_OVERFLOW_EN
      output overflow,
`endif
      output busy, done, sum, c_out
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder bit per cycle, WIDTH-bit result with start/done handshake.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_adder_ctrl_if.slave  bus
);
   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] b_sr_q;
   // Holds the WIDTH-1 most recent sum bits; the current FA bit completes the word.
   logic [WIDTH-2:0] s_sr_q;
   logic             carry_q;
   logic [CntW-1:0]  cnt_q;

   logic             fa_sum;
   logic             fa_cout;
   logic             last_bit;
   logic [WIDTH-1:0] s_next;

   // Single-bit full-adder cell fed from the operand LSBs and the carry flop.
   always_comb begin
      fa_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
      fa_cout  = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
      s_next   = {fa_sum, s_sr_q};
      last_bit = (cnt_q == CntW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         a_sr_q       <= '0;
         b_sr_q       <= '0;
         s_sr_q       <= '0;
         carry_q      <= 1'b0;
         cnt_q        <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.sum      <= '0;
         bus.c_out    <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
         bus.overflow <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         case (state_q)
            StIdle, StDone: begin
               if (bus.start) begin
                  a_sr_q   <= bus.a;
                  b_sr_q   <= bus.b;
                  carry_q  <= bus.c_in;
                  cnt_q    <= '0;
                  state_q  <= StRun;
                  bus.busy <= 1'b1;
               end else begin
                  state_q  <= StIdle;
                  bus.busy <= 1'b0;
               end
            end
            StRun: begin
               a_sr_q  <= a_sr_q >> 1;
               b_sr_q  <= b_sr_q >> 1;
               s_sr_q  <= s_next[WIDTH-1:1];
               carry_q <= fa_cout;
               cnt_q   <= cnt_q + 1'b1;
               if (last_bit) begin
                  bus.sum      <= s_next;
                  bus.c_out    <= fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                  bus.overflow <= carry_q ^ fa_cout;
`endif
                  state_q      <= StDone;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
               end
            end
            default: begin
               state_q  <= StIdle;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8.
// Overflow checks compile only when SERIAL_ADDER_OVERFLOW_EN is defined.
module tb_serial_adder_ctrl;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   serial_adder_ctrl_if #(.WIDTH(8)) bus ();

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Presents operands with start for exactly one edge (the accept edge E0).
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c);
      bus.a     = a;
      bus.b     = b;
      bus.c_in  = c;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("accept_busy", {31'd0, bus.busy}, 32'd1);
      check("accept_done", {31'd0, bus.done}, 32'd0);
   endtask

   // Waits (bounded) for done; lat is the number of edges expected after the current point.
   task automatic wait_done(input string tag, input logic [8:0] exp, input int lat);
      int n;
      int busy_low;
      n        = 0;
      busy_low = 0;
      while (bus.done !== 1'b1 && n < 20) begin
         if (bus.busy !== 1'b1) busy_low++;
         tick();
         n++;
      end
      check({tag, "_busy_in_run"}, busy_low, 0);
      check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
      check({tag, "_latency"}, n, lat);
      check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_result"}, {23'd0, bus.c_out, bus.sum}, {23'd0, exp});
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      int         seen;
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.c_in  = 1'b0;
      #1;
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_done", {31'd0, bus.done}, 32'd0);
      check("reset_result", {23'd0, bus.c_out, bus.sum}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("idle_busy", {31'd0, bus.busy}, 32'd0);

      // Basic vectors; done arrives 8 edges after the accept edge.
      launch(8'h00, 8'h00, 1'b0);
      wait_done("zero", 9'h000, 8);
      tick();
      check("done_pulse_width", {31'd0, bus.done}, 32'd0);
      launch(8'hFF, 8'h01, 1'b0);
      wait_done("ff_p_01", 9'h100, 8);
      launch(8'hA5, 8'h5A, 1'b1);
      wait_done("a5_p_5a_c", 9'h100, 8);
      launch(8'h3C, 8'h42, 1'b0);
      wait_done("3c_p_42", 9'h07E, 8);

      // start held high: operands changing during RUN are ignored, DONE re-accepts.
      bus.a     = 8'h10;
      bus.b     = 8'h20;
      bus.c_in  = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.a = 8'hFF;
      bus.b = 8'hFF;
      wait_done("hold_first", 9'h030, 8);
      tick();
      bus.start = 1'b0;
      check("b2b_busy", {31'd0, bus.busy}, 32'd1);
      tick();
      tick();
      tick();
      check("sum_held_in_run", {23'd0, bus.c_out, bus.sum}, 32'h030);
      wait_done("hold_second", 9'h1FE, 5);

      // Asynchronous reset during bit 4 aborts the addition.
      launch(8'hFF, 8'hFF, 1'b0);
      tick();
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_done", {31'd0, bus.done}, 32'd0);
      check("abort_result", {23'd0, bus.c_out, bus.sum}, 32'd0);
      tick();
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done === 1'b1) seen++;
      end
      check("abort_no_done", seen, 0);
      launch(8'h01, 8'h02, 1'b0);
      wait_done("after_abort", 9'h003, 8);

`ifdef SERIAL_ADDER_OVERFLOW_EN
      launch(8'h7F, 8'h01, 1'b0);
      wait_done("ovf_7f_01", 9'h080, 8);
      check("ovf_7f_01_flag", {31'd0, bus.overflow}, 32'd1);
      launch(8'h80, 8'h80, 1'b0);
      wait_done("ovf_80_80", 9'h100, 8);
      check("ovf_80_80_flag", {31'd0, bus.overflow}, 32'd1);
      launch(8'h05, 8'h03, 1'b0);
      wait_done("ovf_05_03", 9'h008, 8);
      check("ovf_05_03_flag", {31'd0, bus.overflow}, 32'd0);
`endif

      // Random regression, mixing back-to-back starts with idle gaps.
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         if ($urandom_range(0, 1) == 0) tick();
         launch(ra, rb, rc);
         wait_done("random", {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, 8);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
